id_ex_stage: RTL
================

# id_ex_stage

Pipeline register between decode and execute in the five-stage MIPS core. Latches the decoder control bundle (RegDst, ALUSrc, MemToReg, RegWrite, MemRead, MemWrite, Branch, ALUOp) together with operands and register indices. Detects load-use hazards and inserts bubbles. Squashes the instruction in decode when a taken branch resolves downstream. Keeps saturating stall/flush counters for performance debug.

## Interface
- DATA_W, 32, operand/immediate/PC width
- REG_W, 5, register index width
- CNT_W, 16, width of stall/flush counters
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- id_valid  in  1  decode slot holds a real instruction
- id_regdst, id_alusrc, id_memtoreg, id_regwrite, id_memread, id_memwrite, id_branch  in  1 each  decoder control bits
- id_aluop  in  2  decoder ALUOp (00 add, 01 sub, 10 funct, 11 or)
- id_funct  in  6  instr[5:0]
- id_rs, id_rt, id_rd  in  REG_W  instr[25:21], [20:16], [15:11]
- id_rs_data, id_rt_data  in  DATA_W  register-file read data
- id_imm  in  DATA_W  sign-extended immediate
- id_pc4  in  DATA_W  PC+4 of decode instruction
- flush  in  1  taken branch resolved downstream; kill decode instruction
- ex_valid  out  1  execute slot holds a real instruction
- ex_regdst … ex_branch, ex_aluop, ex_funct, ex_rs, ex_rt, ex_rd, ex_rs_data, ex_rt_data, ex_imm, ex_pc4  out  same widths as id_*  registered copies
- stall  out  1  hold PC and IF/ID this cycle
- stall_cnt, flush_cnt  out  CNT_W  saturating event counters

## Operation
- uses_rt = id_regdst | id_memwrite | id_branch (R-type, sw, beq); rs is always used.
- Hazard condition: ex_valid & ex_memread & ex_rt != 0 & id_valid & (ex_rt == id_rs | (uses_rt & ex_rt == id_rt)).
- stall = hazard & ~flush.
- Per cycle, in priority order:
  - **flush**: load a bubble.
  - **stall**: load a bubble. The decode instruction is held upstream and re-presented next cycle.
  - **else**: load all id_* inputs; ex_valid <= id_valid.
- Bubble: ex_valid = 0 and all seven control bits = 0, ALUOp = 00. Data/index fields become don't-care, but are driven to 0.
- If id_valid = 0 on a normal load, the control bits are still loaded as zeros. An invalid slot never writes a register or memory.
- stall_cnt increments on each cycle with stall = 1. flush_cnt increments on each cycle with flush = 1 and id_valid = 1. Both saturate at all-ones and never wrap.
- Register $0 never causes a hazard.

## Timing
- Reset (async assert, sync release on the next clk edge):
  - all ex_* outputs = 0, ex_valid = 0;
  - counters = 0;
  - stall = 0, because it is derived from ex_valid.
- Latency: decode → execute is 1 cycle.
- stall is combinational from current-cycle id_* and registered ex_* state. Load-use costs exactly one bubble: after the bubble, the load is no longer in EX, so stall deasserts.
- flush and stall both high: flush wins, stall = 0, and stall_cnt does not increment.
- Reset asserted mid-stall: outputs clear immediately. After release, the first edge loads id_* normally.
- Back-to-back loads where the second depends on the first: one bubble. Back-to-back loads with no dependence: no bubble.

## Structure
- Shared package `mips_pkg`:
  - opcode constants (OP_RTYPE 000000, OP_LW 100011, OP_SW 101011, OP_BEQ 000100, OP_ORI 001101);
  - ALUOp constants;
  - packed struct `ctrl_t` (7 control bits + ALUOp);
  - constant CTRL_BUBBLE = all zeros.
- One combinational sub-module `hazard_unit`: hazard/stall equation only. The register and counters stay in id_ex_stage.

## Test plan
- Reset: assert rst_n = 0 mid-clock with ex_regwrite = 1 → all outputs 0 immediately, ex_valid = 0; counters 0.
- Pass-through: R-type add, rs = 2, rt = 3, rd = 4, rs_data = 5, rt_data = 7 → next edge ex_regdst = 1, ex_regwrite = 1, ex_aluop = 10, ex_rs_data = 5, ex_rt_data = 7, ex_valid = 1, stall = 0.
- Load-use: lw rt = 8 in EX, then R-type in ID with rs = 8 → stall = 1 for one cycle; ex_valid = 0 with zero controls; R-type enters EX on the following edge; stall_cnt = 1.
- No false hazard:
  - lw rt = 0 followed by rs = 0 → stall = 0;
  - lw rt = 8 followed by ori with rt = 8 (rt not used) → stall = 0.
- Flush priority: flush = 1 while the load-use hazard is present → stall = 0, bubble loaded, flush_cnt = 1, stall_cnt unchanged.
- Saturation: CNT_W = 2, force 5 consecutive stall cycles → stall_cnt stays at 3.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared definitions for the five-stage MIPS core: opcodes, ALUOp encodings
// and the decoder control bundle carried down the pipeline.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ORI   = 6'b001101;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10,
        ALUOP_OR    = 2'b11
    } aluop_e;

    typedef struct packed {
        logic   regdst;
        logic   alusrc;
        logic   memtoreg;
        logic   regwrite;
        logic   memread;
        logic   memwrite;
        logic   branch;
        aluop_e aluop;
    } ctrl_t;

    localparam ctrl_t CTRL_BUBBLE = '0;

endpackage

// File: rtl/hazard_unit.sv
// Load-use hazard detection between the load in EX and the instruction in ID.
// A resolving branch (flush) overrides the stall since ID is being killed anyway.
module hazard_unit #(
    parameter int REG_W = 5
) (
    input  logic             ex_valid,
    input  logic             ex_memread,
    input  logic [REG_W-1:0] ex_rt,
    input  logic             id_valid,
    input  logic             id_regdst,
    input  logic             id_memwrite,
    input  logic             id_branch,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             flush,
    output logic             stall
);

    logic uses_rt;
    logic hazard;

    // R-type, sw and beq read rt; everything else only reads rs.
    assign uses_rt = id_regdst | id_memwrite | id_branch;

    assign hazard = ex_valid & ex_memread & (ex_rt != '0) & id_valid &
                    ((ex_rt == id_rs) | (uses_rt & (ex_rt == id_rt)));

    assign stall = hazard & ~flush;

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: latches the decode bundle, inserts a bubble on
// load-use stall or flush, and counts stall/flush events (saturating).
module id_ex_stage
    import mips_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    input  logic              id_regdst,
    input  logic              id_alusrc,
    input  logic              id_memtoreg,
    input  logic              id_regwrite,
    input  logic              id_memread,
    input  logic              id_memwrite,
    input  logic              id_branch,
    input  logic [1:0]        id_aluop,
    input  logic [5:0]        id_funct,
    input  logic [REG_W-1:0]  id_rs,
    input  logic [REG_W-1:0]  id_rt,
    input  logic [REG_W-1:0]  id_rd,
    input  logic [DATA_W-1:0] id_rs_data,
    input  logic [DATA_W-1:0] id_rt_data,
    input  logic [DATA_W-1:0] id_imm,
    input  logic [DATA_W-1:0] id_pc4,
    input  logic              flush,
    output logic              ex_valid,
    output logic              ex_regdst,
    output logic              ex_alusrc,
    output logic              ex_memtoreg,
    output logic              ex_regwrite,
    output logic              ex_memread,
    output logic              ex_memwrite,
    output logic              ex_branch,
    output logic [1:0]        ex_aluop,
    output logic [5:0]        ex_funct,
    output logic [REG_W-1:0]  ex_rs,
    output logic [REG_W-1:0]  ex_rt,
    output logic [REG_W-1:0]  ex_rd,
    output logic [DATA_W-1:0] ex_rs_data,
    output logic [DATA_W-1:0] ex_rt_data,
    output logic [DATA_W-1:0] ex_imm,
    output logic [DATA_W-1:0] ex_pc4,
    output logic              stall,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    ctrl_t id_ctrl;
    ctrl_t ex_ctrl;
    logic  load_bubble;

    hazard_unit #(.REG_W(REG_W)) u_hazard (
        .ex_valid    (ex_valid),
        .ex_memread  (ex_ctrl.memread),
        .ex_rt       (ex_rt),
        .id_valid    (id_valid),
        .id_regdst   (id_regdst),
        .id_memwrite (id_memwrite),
        .id_branch   (id_branch),
        .id_rs       (id_rs),
        .id_rt       (id_rt),
        .flush       (flush),
        .stall       (stall)
    );

    // An invalid decode slot carries zero controls so it can never write state.
    always_comb begin
        // NOTE: assign a default before any conditional so no path leaves id_ctrl unassigned (latch).
        id_ctrl = CTRL_BUBBLE;
        if (id_valid) begin
            id_ctrl = '{regdst:   id_regdst,
                        alusrc:   id_alusrc,
                        memtoreg: id_memtoreg,
                        regwrite: id_regwrite,
                        memread:  id_memread,
                        memwrite: id_memwrite,
                        branch:   id_branch,
                        aluop:    aluop_e'(id_aluop)};
        end
    end

    assign load_bubble = flush | stall;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n || load_bubble) begin
            ex_valid   <= 1'b0;
            ex_ctrl    <= CTRL_BUBBLE;
            ex_funct   <= '0;
            ex_rs      <= '0;
            ex_rt      <= '0;
            ex_rd      <= '0;
            ex_rs_data <= '0;
            ex_rt_data <= '0;
            ex_imm     <= '0;
            ex_pc4     <= '0;
        end else begin
            ex_valid   <= id_valid;
            ex_ctrl    <= id_ctrl;
            ex_funct   <= id_funct;
            ex_rs      <= id_rs;
            ex_rt      <= id_rt;
            ex_rd      <= id_rd;
            ex_rs_data <= id_rs_data;
            ex_rt_data <= id_rt_data;
            ex_imm     <= id_imm;
            ex_pc4     <= id_pc4;
        end
    end

    // Counters saturate at all-ones so a long run never reads back as small.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (stall && (stall_cnt != '1)) stall_cnt <= stall_cnt + CNT_W'(1);
            if (flush && id_valid && (flush_cnt != '1)) flush_cnt <= flush_cnt + CNT_W'(1);
        end
    end

    assign ex_regdst   = ex_ctrl.regdst;
    assign ex_alusrc   = ex_ctrl.alusrc;
    assign ex_memtoreg = ex_ctrl.memtoreg;
    assign ex_regwrite = ex_ctrl.regwrite;
    assign ex_memread  = ex_ctrl.memread;
    assign ex_memwrite = ex_ctrl.memwrite;
    assign ex_branch   = ex_ctrl.branch;
    assign ex_aluop    = ex_ctrl.aluop;

endmodule
